// File: rtl/mem_stage_pkg.sv
// Shared types for the memory-access stage: FSM states, op decode, widths.
// No logic; latency/backpressure apply to the modules that import it.
// Store beats load when both request bits are set.
package mem_stage_pkg;

  localparam int DEFAULT_WAIT_CYCLES = 2;
  localparam int REG_IDX_W           = 3;
  localparam int DATA_W              = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_RD_DONE,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD
  } mem_state_e;

  typedef enum logic [1:0] {
    MEM_NONE,
    MEM_LOAD,
    MEM_STORE
  } mem_op_e;

  function automatic mem_op_e decode_op(input logic mem_read, input logic mem_write);
    if (mem_write) return MEM_STORE;
    if (mem_read)  return MEM_LOAD;
    return MEM_NONE;
  endfunction

endpackage

// File: rtl/mem_stage_sram_if.sv
// Async SRAM sequencer: wait counter, FSM and registered SRAM pins.
// Load: WAIT_CYCLES strobe then done cycle; store: setup, WAIT_CYCLES WE pulse, hold.
// Only starts from idle; hold tells the stage to keep upstream frozen.
module mem_stage_sram_if
  import mem_stage_pkg::*;
#(
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
  parameter int RAM_AW      = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_rd,
  input  logic              start_wr,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              idle,
  output logic              hold,
  output logic              rd_sample,
  output logic [RAM_AW-1:0] RamAddr,
  output logic [DATA_W-1:0] RamDataOut,
  output logic              RamDataOe,
  output logic              RamEN_n,
  output logic              RamOE_n,
  output logic              RamWE_n
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES - 1);

  mem_state_e    state;
  mem_state_e    nxt;
  logic [CW-1:0] cnt;

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE: begin
        if (start_wr)      nxt = ST_WR_SETUP;
        else if (start_rd) nxt = ST_RD_WAIT;
      end
      ST_RD_WAIT:  if (cnt == '0) nxt = ST_RD_DONE;
      ST_RD_DONE:  nxt = ST_IDLE;
      ST_WR_SETUP: nxt = ST_WR_PULSE;
      ST_WR_PULSE: if (cnt == '0) nxt = ST_WR_HOLD;
      ST_WR_HOLD:  nxt = ST_IDLE;
      default:     nxt = ST_IDLE;
    endcase
  end

  assign idle      = (state == ST_IDLE);
  // Release one cycle early so the next instruction lands exactly as we go idle.
  assign hold      = (state != ST_IDLE) && (nxt != ST_IDLE);
  assign rd_sample = (state == ST_RD_WAIT) && (cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      RamAddr    <= '0;
      RamDataOut <= '0;
      RamDataOe  <= 1'b0;
      RamEN_n    <= 1'b1;
      RamOE_n    <= 1'b1;
      RamWE_n    <= 1'b1;
    end else begin
      state <= nxt;
      if (state != nxt)     cnt <= CNT_LOAD;
      else if (cnt != '0)   cnt <= cnt - CW'(1);

      if (state == ST_IDLE && nxt != ST_IDLE) RamAddr    <= RAM_AW'(addr);
      if (nxt == ST_WR_SETUP && state == ST_IDLE) RamDataOut <= wdata;

      // Pins follow the state being entered so they are glitch-free flops.
      RamEN_n   <= !(nxt == ST_RD_WAIT || nxt == ST_WR_SETUP ||
                     nxt == ST_WR_PULSE || nxt == ST_WR_HOLD);
      RamOE_n   <= !(nxt == ST_RD_WAIT);
      RamWE_n   <= !(nxt == ST_WR_PULSE);
      RamDataOe <= (nxt == ST_WR_SETUP || nxt == ST_WR_PULSE || nxt == ST_WR_HOLD);
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: ALU ops pass through, loads/stores run on the external SRAM.
// ALU result 1 cycle; load WAIT_CYCLES+1; store 2+WAIT_CYCLES with no write-back.
// Stall holds EX/MEM from accept until the cycle before the SRAM FSM goes idle.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
  parameter int RAM_AW      = 18
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 InValid,
  input  logic                 MemRead,
  input  logic                 MemWrite,
  input  logic [DATA_W-1:0]    Addr,
  input  logic [DATA_W-1:0]    StoreData,
  input  logic [REG_IDX_W-1:0] InRd,
  input  logic                 InRegWrite,
  input  logic                 Flush,
  output logic                 Stall,
  output logic                 WbValid,
  output logic [DATA_W-1:0]    WbData,
  output logic [REG_IDX_W-1:0] WbRd,
  output logic                 WbRegWrite,
  output logic [RAM_AW-1:0]    RamAddr,
  output logic [DATA_W-1:0]    RamDataOut,
  output logic                 RamDataOe,
  input  logic [DATA_W-1:0]    RamDataIn,
  output logic                 RamEN_n,
  output logic                 RamOE_n,
  output logic                 RamWE_n
);

  mem_op_e              op;
  logic                 accept;
  logic                 start_rd;
  logic                 start_wr;
  logic                 idle;
  logic                 hold;
  logic                 rd_sample;
  logic [REG_IDX_W-1:0] pend_rd;
  logic                 pend_rw;

  assign op       = decode_op(MemRead, MemWrite);
  // Gated by rst so Stall is quiet while reset is asserted.
  assign accept   = rst && InValid && !Flush && idle;
  assign start_rd = accept && (op == MEM_LOAD);
  assign start_wr = accept && (op == MEM_STORE);
  assign Stall    = hold || start_rd || start_wr;

  mem_stage_sram_if #(
    .WAIT_CYCLES(WAIT_CYCLES),
    .RAM_AW     (RAM_AW)
  ) u_sram_if (
    .clk       (clk),
    .rst       (rst),
    .start_rd  (start_rd),
    .start_wr  (start_wr),
    .addr      (Addr),
    .wdata     (StoreData),
    .idle      (idle),
    .hold      (hold),
    .rd_sample (rd_sample),
    .RamAddr   (RamAddr),
    .RamDataOut(RamDataOut),
    .RamDataOe (RamDataOe),
    .RamEN_n   (RamEN_n),
    .RamOE_n   (RamOE_n),
    .RamWE_n   (RamWE_n)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      WbValid    <= 1'b0;
      WbData     <= '0;
      WbRd       <= '0;
      WbRegWrite <= 1'b0;
      pend_rd    <= '0;
      pend_rw    <= 1'b0;
    end else begin
      WbValid <= 1'b0;
      if (start_rd) begin
        pend_rd <= InRd;
        pend_rw <= InRegWrite;
      end
      if (accept && op == MEM_NONE) begin
        WbValid    <= 1'b1;
        WbData     <= Addr;
        WbRd       <= InRd;
        WbRegWrite <= InRegWrite;
      end else if (rd_sample) begin
        WbValid    <= 1'b1;
        WbData     <= RamDataIn;
        WbRd       <= pend_rd;
        WbRegWrite <= pend_rw;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed and random ALU/load/store traffic against a
// cycle-timing model and an independent reference memory.
module tb_mem_stage;

  localparam int W      = 2;
  localparam int RAM_AW = 18;
  localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, mem_read, mem_write, in_rw, flush;
  logic [15:0]       addr, sdata;
  logic [2:0]        in_rd;
  logic              stall, wbv, wbrw;
  logic [15:0]       wbd;
  logic [2:0]        wbrd;
  logic [RAM_AW-1:0] ram_addr;
  logic [15:0]       ram_dout, ram_din;
  logic              ram_doe, ram_en_n, ram_oe_n, ram_we_n;

  int tests = 0;
  int fails = 0;

  bit          exp_wbv;
  logic [15:0] exp_wbd;
  logic [2:0]  exp_wbrd;
  bit          exp_wbrw;

  logic [15:0] sram_w  [logic [15:0]];
  logic [15:0] ref_mem [logic [15:0]];

  always #5 clk = ~clk;

  mem_stage #(.WAIT_CYCLES(W), .RAM_AW(RAM_AW)) dut (
    .clk(clk), .rst(rst), .InValid(in_valid), .MemRead(mem_read), .MemWrite(mem_write),
    .Addr(addr), .StoreData(sdata), .InRd(in_rd), .InRegWrite(in_rw), .Flush(flush),
    .Stall(stall), .WbValid(wbv), .WbData(wbd), .WbRd(wbrd), .WbRegWrite(wbrw),
    .RamAddr(ram_addr), .RamDataOut(ram_dout), .RamDataOe(ram_doe), .RamDataIn(ram_din),
    .RamEN_n(ram_en_n), .RamOE_n(ram_oe_n), .RamWE_n(ram_we_n)
  );

  function automatic logic [15:0] init_val(input logic [15:0] a);
    if (a == 16'h0010) return 16'h5A5A;
    return (a ^ 16'hC3A5) + 16'h0101;
  endfunction

  function automatic logic [15:0] sram_rd(input logic [15:0] a);
    if (sram_w.exists(a)) return sram_w[a];
    return init_val(a);
  endfunction

  function automatic logic [15:0] model_rd(input logic [15:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_val(a);
  endfunction

  // Asynchronous SRAM: read while CE/OE low, write on the WE rising edge.
  always @(*) begin
    ram_din = 16'hDEAD;
    if (!ram_en_n && !ram_oe_n) ram_din = sram_rd(ram_addr[15:0]);
  end

  always @(posedge ram_we_n) begin
    if (!ram_en_n && ram_doe) sram_w[ram_addr[15:0]] = ram_dout;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_pins(input string tag, input bit e_stall, input bit e_en_low,
                            input bit e_oe_low, input bit e_we_low, input bit e_doe,
                            input logic [15:0] e_addr, input logic [15:0] e_dout);
    chk({tag, ".stall"}, 32'(stall),    32'(e_stall));
    chk({tag, ".en_n"},  32'(ram_en_n), 32'(!e_en_low));
    chk({tag, ".oe_n"},  32'(ram_oe_n), 32'(!e_oe_low));
    chk({tag, ".we_n"},  32'(ram_we_n), 32'(!e_we_low));
    chk({tag, ".doe"},   32'(ram_doe),  32'(e_doe));
    if (e_en_low) chk({tag, ".addr"}, 32'(ram_addr), {14'd0, 18'(e_addr)});
    if (e_doe)    chk({tag, ".dout"}, 32'(ram_dout), 32'(e_dout));
    chk({tag, ".wbv"}, 32'(wbv), 32'(exp_wbv));
    if (exp_wbv) begin
      chk({tag, ".wbd"},  32'(wbd),  32'(exp_wbd));
      chk({tag, ".wbrd"}, 32'(wbrd), 32'(exp_wbrd));
      chk({tag, ".wbrw"}, 32'(wbrw), 32'(exp_wbrw));
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".stall"}, 32'(stall), 32'(0));
    chk({tag, ".wbv"},   32'(wbv), 32'(0));
    chk({tag, ".wbd"},   32'(wbd), 32'(0));
    chk({tag, ".wbrd"},  32'(wbrd), 32'(0));
    chk({tag, ".wbrw"},  32'(wbrw), 32'(0));
    chk({tag, ".en_n"},  32'(ram_en_n), 32'(1));
    chk({tag, ".oe_n"},  32'(ram_oe_n), 32'(1));
    chk({tag, ".we_n"},  32'(ram_we_n), 32'(1));
    chk({tag, ".doe"},   32'(ram_doe), 32'(0));
    chk({tag, ".addr"},  32'(ram_addr), 32'(0));
    chk({tag, ".dout"},  32'(ram_dout), 32'(0));
  endtask

  task automatic idle_cycle(input string tag);
    @(negedge clk);
    in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; flush = 1'b0;
    #1;
    check_pins(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    exp_wbv = 1'b0;
  endtask

  // One instruction, checked cycle by cycle from its accept cycle (k=0) until the
  // stage is ready for the next one; the caller may issue the next op right after.
  task automatic run_op(input string tag, input int kind, input logic [15:0] a,
                        input logic [15:0] sd, input logic [2:0] rd, input bit rw,
                        input bit fl, input bit fl_busy, input int abort_k);
    bit busy;
    int n;
    bit e_stall, e_en, e_oe, e_we, e_doe;
    busy = (kind != K_ALU) && !fl;
    n = !busy ? 1 : ((kind == K_LOAD) ? W + 2 : W + 3);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k == 0) begin
        in_valid  = 1'b1;
        mem_write = (kind == K_STORE);
        mem_read  = (kind == K_LOAD) || (kind == K_STORE && $urandom_range(0, 1) == 1);
        addr = a; sdata = sd; in_rd = rd; in_rw = rw; flush = fl;
      end else if (fl_busy) begin
        flush = 1'b1;
      end
      #1;
      e_stall = busy && ((kind == K_LOAD) ? (k <= W) : (k <= W + 1));
      e_en    = busy && (k >= 1) && ((kind == K_LOAD) ? (k <= W) : (k <= W + 2));
      e_oe    = busy && (kind == K_LOAD) && (k >= 1) && (k <= W);
      e_we    = busy && (kind == K_STORE) && (k >= 2) && (k <= W + 1);
      e_doe   = busy && (kind == K_STORE) && (k >= 1);
      if (busy && kind == K_LOAD && k == W + 1) begin
        exp_wbv = 1'b1; exp_wbd = model_rd(a); exp_wbrd = rd; exp_wbrw = rw;
      end
      check_pins(tag, e_stall, e_en, e_oe, e_we, e_doe, a, sd);
      exp_wbv = 1'b0;
      if (k == abort_k) begin
        rst = 1'b0;
        #1;
        check_reset({tag, ".rst"});
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        rst = 1'b1;
        return;
      end
    end
    if (kind == K_ALU && !fl) begin
      exp_wbv = 1'b1; exp_wbd = a; exp_wbrd = rd; exp_wbrw = rw;
    end
    if (kind == K_STORE && busy) ref_mem[a] = sd;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    addr = '0; sdata = '0; in_rd = '0; in_rw = 1'b0; flush = 1'b0;
    exp_wbv = 1'b0; exp_wbd = '0; exp_wbrd = '0; exp_wbrw = 1'b0;

    repeat (2) @(negedge clk);
    in_valid = 1'b1; mem_read = 1'b1; addr = 16'h0010;
    #1;
    check_reset("reset");
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; mem_read = 1'b0;
    idle_cycle("idle0");

    run_op("alu_fe0e", K_ALU, 16'hFE0E, 16'h0, 3'd3, 1'b1, 1'b0, 1'b0, -1);
    idle_cycle("alu_wb");
    idle_cycle("alu_after");

    run_op("load_0010", K_LOAD, 16'h0010, 16'h0, 3'd5, 1'b1, 1'b0, 1'b0, -1);
    idle_cycle("load_after");

    run_op("store_1234", K_STORE, 16'h1234, 16'hBEEF, 3'd0, 1'b0, 1'b0, 1'b0, -1);
    run_op("load_1234", K_LOAD, 16'h1234, 16'h0, 3'd2, 1'b1, 1'b0, 1'b0, -1);
    run_op("alu_b2b", K_ALU, 16'h0042, 16'h0, 3'd7, 1'b0, 1'b0, 1'b0, -1);
    run_op("alu_b2b2", K_ALU, 16'h8001, 16'h0, 3'd1, 1'b1, 1'b0, 1'b0, -1);
    idle_cycle("b2b_after");

    run_op("flush_load", K_LOAD, 16'h0020, 16'h0, 3'd4, 1'b1, 1'b1, 1'b0, -1);
    idle_cycle("flush_after");
    run_op("fbusy_load", K_LOAD, 16'h0010, 16'h0, 3'd6, 1'b1, 1'b0, 1'b1, -1);
    run_op("fbusy_store", K_STORE, 16'h0030, 16'h1357, 3'd0, 1'b0, 1'b0, 1'b1, -1);
    run_op("fbusy_chk", K_LOAD, 16'h0030, 16'h0, 3'd1, 1'b1, 1'b0, 1'b0, -1);
    idle_cycle("fbusy_after");

    for (int i = 0; i < 80; i++) begin
      int          kind;
      logic [15:0] a;
      kind = $urandom_range(0, 2);
      a = (kind == K_ALU) ? 16'($urandom) : 16'($urandom_range(0, 15));
      run_op("rand", kind, a, 16'($urandom), 3'($urandom), 1'($urandom),
             $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, -1);
      if ($urandom_range(0, 3) == 0) idle_cycle("rand_idle");
    end
    idle_cycle("rand_after");

    run_op("store_abort", K_STORE, 16'hF00D, 16'hAAAA, 3'd0, 1'b0, 1'b0, 1'b0, 3);
    exp_wbv = 1'b0;
    idle_cycle("abort_idle");
    run_op("load_recover", K_LOAD, 16'h0010, 16'h0, 3'd3, 1'b0, 1'b0, 1'b0, -1);
    idle_cycle("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
